// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array sequencer.
//   ctrl_state_e   : sequencer FSM states
//   PE_LAT_DEFAULT : default cycles per PE hop (3-cycle madd + output register)
//   win_start()    : skew offset, in cycles after the first STREAM cycle, of
//                    the window belonging to systolic position idx
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN,
    DONE
  } ctrl_state_e;

  localparam int unsigned PE_LAT_DEFAULT = 4;

  function automatic int unsigned win_start(input int unsigned idx,
                                            input int unsigned pe_lat = PE_LAT_DEFAULT);
    return idx * pe_lat;
  endfunction

endpackage

// File: rtl/systolic_skew_window.sv
// One skewed stream window: a delay down-counter followed by a CNT_W window
// counter. A trig pulse in the cycle before the first STREAM cycle (S) opens
// the window OFFSET cycles after S; en stays high for num cycles while addr
// counts 0..num-1, then addr holds its last value.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   trig       : one-cycle pulse in cycle S-1 (only issued when num != 0)
//   num        : window length, stable for the whole job
//   en, addr   : registered window strobe and vector index
module systolic_skew_window #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned OFFSET = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trig,
  input  logic [CNT_W-1:0] num,
  output logic             en,
  output logic [CNT_W-1:0] addr
);

  localparam int unsigned DLY_W    = (OFFSET > 1) ? $clog2(OFFSET) : 1;
  localparam int unsigned DLY_INIT = (OFFSET > 0) ? OFFSET - 1 : 0;

  logic             armed_q, armed_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic             en_q, en_d;
  logic [CNT_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0] last_idx;

  assign last_idx = num - CNT_W'(1);

  always_comb begin
    armed_d = armed_q;
    dly_d   = dly_q;
    en_d    = en_q;
    addr_d  = addr_q;
    if (trig) begin
      // trig arrives one cycle early, so a zero offset opens immediately and
      // a non-zero offset waits OFFSET-1 further edges
      if (OFFSET == 0) begin
        en_d   = 1'b1;
        addr_d = '0;
      end else begin
        armed_d = 1'b1;
        dly_d   = DLY_W'(DLY_INIT);
      end
    end else if (armed_q) begin
      if (dly_q == '0) begin
        armed_d = 1'b0;
        en_d    = 1'b1;
        addr_d  = '0;
      end else begin
        dly_d = dly_q - DLY_W'(1);
      end
    end else if (en_q) begin
      // compare against num-1 so the maximum count never wraps
      if (addr_q == last_idx) begin
        en_d = 1'b0;
      end else begin
        addr_d = addr_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      armed_q <= 1'b0;
      dly_q   <= '0;
      en_q    <= 1'b0;
      addr_q  <= '0;
    end else begin
      armed_q <= armed_d;
      dly_q   <= dly_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
    end
  end

  assign en   = en_q;
  assign addr = addr_q;

endmodule

// File: rtl/systolic_array_ctrl.sv
// Sequencer for a ROWS x COLS weight-stationary systolic PE array.
// A job preloads weights row by row (bottom row first), streams N input
// vectors with per-row skew, strobes per-column results as bottom-row sums
// become valid, then pulses done. All outputs are registered.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   start, num_vectors    : job request and vector count (latched in IDLE)
//   busy, done            : job in progress / one-cycle end-of-job pulse
//   arr_enable            : enable_in of all PEs
//   arr_ld_weight         : ld_weight_in of column-0 PEs
//   w_rd_addr             : weight row placed on the top-row in_sum
//   x_row_en, x_row_addr  : per-row input strobe and vector index
//   y_col_valid, y_col_addr : per-column result strobe and vector index
//   perf_cycles           : busy cycles of the last job (SYSTOLIC_CTRL_PERF_EN only)
// Macro SYSTOLIC_CTRL_PERF_EN adds the perf_cycles port and its counter.
module systolic_array_ctrl
  import systolic_pkg::*;
#(
  parameter  int unsigned ROWS   = 4,
  parameter  int unsigned COLS   = 4,
  parameter  int unsigned PE_LAT = PE_LAT_DEFAULT,
  parameter  int unsigned CNT_W  = 16,
  localparam int unsigned W_AW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [CNT_W-1:0]        num_vectors,
  output logic                    busy,
  output logic                    done,
  output logic                    arr_enable,
  output logic                    arr_ld_weight,
  output logic [W_AW-1:0]         w_rd_addr,
  output logic [ROWS-1:0]         x_row_en,
  output logic [ROWS*CNT_W-1:0]   x_row_addr,
  output logic [COLS-1:0]         y_col_valid,
  output logic [COLS*CNT_W-1:0]   y_col_addr
`ifdef SYSTOLIC_CTRL_PERF_EN
  ,
  output logic [31:0]             perf_cycles
`endif
);

  ctrl_state_e      state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [W_AW-1:0]  w_rd_addr_q, w_rd_addr_d;
  logic             zero_hold_q, zero_hold_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             arr_enable_q, arr_enable_d;
  logic             arr_ld_weight_q, arr_ld_weight_d;
  logic             win_trig;
  logic [CNT_W-1:0] last_idx;
  logic [CNT_W-1:0] last_row_addr;
  logic [CNT_W-1:0] last_col_addr;

  assign last_idx      = n_q - CNT_W'(1);
  assign last_row_addr = x_row_addr[(ROWS-1)*CNT_W +: CNT_W];
  assign last_col_addr = y_col_addr[(COLS-1)*CNT_W +: CNT_W];

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    w_rd_addr_d = w_rd_addr_q;
    zero_hold_d = zero_hold_q;
    win_trig    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          n_d = num_vectors;
          if (num_vectors == '0) begin
            // an empty job spends one extra busy cycle before its done pulse
            state_d     = DONE;
            zero_hold_d = 1'b1;
          end else begin
            state_d     = LOAD_W;
            w_rd_addr_d = W_AW'(ROWS - 1);
          end
        end
      end
      LOAD_W: begin
        if (w_rd_addr_q == '0) begin
          state_d  = STREAM;
          win_trig = 1'b1;
        end else begin
          w_rd_addr_d = w_rd_addr_q - W_AW'(1);
        end
      end
      STREAM: begin
        if (x_row_en[ROWS-1] && (last_row_addr == last_idx)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (y_col_valid[COLS-1] && (last_col_addr == last_idx)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (zero_hold_q) begin
          zero_hold_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d          = (state_d != IDLE);
    done_d          = (state_d == DONE) && !zero_hold_d;
    arr_enable_d    = (state_d == LOAD_W) || (state_d == STREAM) || (state_d == DRAIN);
    arr_ld_weight_d = (state_d == LOAD_W);
  end

`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0] perf_q, perf_d;

  // restarting at 1 counts the first LOAD_W cycle; increments stop once the
  // next cycle is idle, which freezes the value from DONE onward
  always_comb begin
    perf_d = perf_q;
    if ((state_q == IDLE) && start) begin
      perf_d = 32'd1;
    end else if (busy_d && (perf_q != '1)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      n_q             <= '0;
      w_rd_addr_q     <= '0;
      zero_hold_q     <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      arr_enable_q    <= 1'b0;
      arr_ld_weight_q <= 1'b0;
`ifdef SYSTOLIC_CTRL_PERF_EN
      perf_q          <= '0;
`endif
    end else begin
      state_q         <= state_d;
      n_q             <= n_d;
      w_rd_addr_q     <= w_rd_addr_d;
      zero_hold_q     <= zero_hold_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      arr_enable_q    <= arr_enable_d;
      arr_ld_weight_q <= arr_ld_weight_d;
`ifdef SYSTOLIC_CTRL_PERF_EN
      perf_q          <= perf_d;
`endif
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign arr_enable    = arr_enable_q;
  assign arr_ld_weight = arr_ld_weight_q;
  assign w_rd_addr     = w_rd_addr_q;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    systolic_skew_window #(
      .CNT_W  (CNT_W),
      .OFFSET (win_start(r, PE_LAT))
    ) u_win (
      .clk   (clk),
      .reset (reset),
      .trig  (win_trig),
      .num   (n_q),
      .en    (x_row_en[r]),
      .addr  (x_row_addr[r*CNT_W +: CNT_W])
    );
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col
    systolic_skew_window #(
      .CNT_W  (CNT_W),
      .OFFSET (win_start(ROWS + c, PE_LAT))
    ) u_win (
      .clk   (clk),
      .reset (reset),
      .trig  (win_trig),
      .num   (n_q),
      .en    (y_col_valid[c]),
      .addr  (y_col_addr[c*CNT_W +: CNT_W])
    );
  end

endmodule
